wb_stage: RTL and testbench

Parametrised registered writeback stage for the RISC-V pipeline. It selects the writeback source from ALU, load data, PC+4 or immediate, and aligns and sign-/zero-extends load data. It holds the pipeline while a variable-latency load response is outstanding. It drives the register-file write port one cycle after the result is known and counts retired writebacks.

---
 rtl/wb_stage_if.sv | 40 ++++
 rtl/wb_stage.sv | 118 +++++++++++
 tb/tb_wb_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback stage bus: upstream op, memory response and register-file write port.
interface wb_stage_if #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
);
   localparam int AW = $clog2(WIDTH/8);

   logic              in_valid;
   logic              in_ready;
   logic              reg_write;
   logic [REG_AW-1:0] rd_addr;
   logic [1:0]        wb_sel;
   logic [2:0]        load_funct3;
   logic [AW-1:0]     addr_lo;
   logic [WIDTH-1:0]  alu_data;
   logic [WIDTH-1:0]  pc_plus4;
   logic [WIDTH-1:0]  imm_data;
   logic [WIDTH-1:0]  mem_rdata;
   logic              mem_rvalid;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [WIDTH-1:0]  rf_wdata;
   logic              load_pending;
   logic              load_misaligned;
   logic [31:0]       retire_count;

   modport master (
      output in_valid, reg_write, rd_addr, wb_sel, load_funct3, addr_lo,
             alu_data, pc_plus4, imm_data, mem_rdata, mem_rvalid,
      input  in_ready, rf_we, rf_waddr, rf_wdata, load_pending,
             load_misaligned, retire_count
   );

   modport slave (
      input  in_valid, reg_write, rd_addr, wb_sel, load_funct3, addr_lo,
             alu_data, pc_plus4, imm_data, mem_rdata, mem_rvalid,
      output in_ready, rf_we, rf_waddr, rf_wdata, load_pending,
             load_misaligned, retire_count
   );
endinterface

// File: rtl/wb_stage.sv
// Registered writeback stage: source select, load align/extend, stall on
// outstanding load response, retire counter.
module wb_stage #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);
   localparam int AW = $clog2(WIDTH/8);

   typedef enum logic {IDLE, WAIT_MEM} state_t;
   state_t state, state_nx;

   logic [REG_AW-1:0] ld_rd;
   logic              ld_rw;
   logic [2:0]        ld_f3;
   logic [AW-1:0]     ld_lo;

   logic             accept, is_load, mis, resp;
   logic [WIDTH-1:0] src, sh, mask, ld_res;
   logic             sgn_bit;
   int               nb;

   assign bus.in_ready     = (state == IDLE);
   assign bus.load_pending = (state == WAIT_MEM);
   assign accept  = bus.in_valid && (state == IDLE);
   assign is_load = (bus.wb_sel == 2'd1);
   assign resp    = (state == WAIT_MEM) && bus.mem_rvalid;

   always_comb begin
      src = bus.alu_data;
      case (bus.wb_sel)
         2'd2:    src = bus.pc_plus4;
         2'd3:    src = bus.imm_data;
         default: src = bus.alu_data;
      endcase
   end

   // Illegal encodings for this width fold into the misaligned error.
   always_comb begin
      mis = 1'b0;
      case (bus.load_funct3)
         3'b001, 3'b101: mis = bus.addr_lo[0];
         3'b010:         mis = |bus.addr_lo[1:0];
         3'b110:         mis = (WIDTH == 32) ? 1'b1 : |bus.addr_lo[1:0];
         3'b011:         mis = (WIDTH == 32) ? 1'b1 : |bus.addr_lo;
         3'b111:         mis = 1'b1;
         default:        mis = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (accept && is_load && !mis) state_nx = WAIT_MEM;
         WAIT_MEM: if (bus.mem_rvalid)            state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Mask covers the loaded size; its top bit picks the sign bit to replicate.
   always_comb begin
      sh = bus.mem_rdata >> {ld_lo, 3'b000};
      case (ld_f3[1:0])
         2'd0:    nb = 8;
         2'd1:    nb = 16;
         2'd2:    nb = 32;
         default: nb = WIDTH;
      endcase
      mask    = ~({WIDTH{1'b1}} << nb);
      sgn_bit = |(sh & mask & ~(mask >> 1));
      ld_res  = (sh & mask) | ((!ld_f3[2] && sgn_bit) ? ~mask : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         bus.rf_we           <= 1'b0;
         bus.rf_waddr        <= '0;
         bus.rf_wdata        <= '0;
         bus.load_misaligned <= 1'b0;
         bus.retire_count    <= '0;
         ld_rd               <= '0;
         ld_rw               <= 1'b0;
         ld_f3               <= '0;
         ld_lo               <= '0;
      end else begin
         state               <= state_nx;
         bus.rf_we           <= 1'b0;
         bus.load_misaligned <= 1'b0;
         if (accept && !is_load) begin
            bus.rf_waddr <= bus.rd_addr;
            bus.rf_wdata <= src;
            if (bus.reg_write && bus.rd_addr != '0) begin
               bus.rf_we        <= 1'b1;
               bus.retire_count <= bus.retire_count + 32'd1;
            end
         end else if (accept) begin
            if (mis) bus.load_misaligned <= 1'b1;
            else begin
               ld_rd <= bus.rd_addr;
               ld_rw <= bus.reg_write;
               ld_f3 <= bus.load_funct3;
               ld_lo <= bus.addr_lo;
            end
         end else if (resp) begin
            bus.rf_waddr <= ld_rd;
            bus.rf_wdata <= ld_res;
            if (ld_rw && ld_rd != '0) begin
               bus.rf_we        <= 1'b1;
               bus.retire_count <= bus.retire_count + 32'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage (WIDTH=32 and WIDTH=64 instances).
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_stage_if #(.WIDTH(32), .REG_AW(5)) b32 ();
   wb_stage_if #(.WIDTH(64), .REG_AW(5)) b64 ();

   wb_stage #(.WIDTH(32), .REG_AW(5)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   wb_stage #(.WIDTH(64), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .bus(b64));

   int errors = 0;
   int checks = 0;
   int exp_ret32 = 0;
   int exp_ret64 = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: assemble the loaded bytes one at a time, then extend to w bits.
   function automatic logic [63:0] ld_model(input logic [63:0] word, input int w,
                                            input int f3, input int a);
      int n;
      logic [63:0] v;
      n = 1 << (f3 & 3);
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(a+i) +: 8];
      if (f3 < 4 && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      if (w == 32) v = {32'd0, v[31:0]};
      return v;
   endfunction

   function automatic bit mis_model(input int w, input int f3, input int a);
      if (f3 == 7 || (w == 32 && (f3 == 3 || f3 == 6))) return 1'b1;
      return (a % (1 << (f3 & 3))) != 0;
   endfunction

   task automatic load32(input int f3, input int a, input logic [31:0] word,
                         input int lat, input logic [4:0] rd, input bit rw);
      logic [31:0] exp;
      bit exp_we;
      b32.in_valid = 1'b1; b32.wb_sel = 2'd1; b32.load_funct3 = 3'(f3);
      b32.addr_lo = 2'(a); b32.rd_addr = rd; b32.reg_write = rw;
      b32.alu_data = $urandom;
      tick();
      b32.in_valid = 1'b0; b32.wb_sel = 2'd0;
      if (mis_model(32, f3, a)) begin
         checks++;
         if (b32.load_misaligned !== 1'b1 || b32.rf_we !== 1'b0 || b32.in_ready !== 1'b1
             || b32.load_pending !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse f3=%0d a=%0d: mis=%b we=%b rdy=%b pend=%b, need 1 0 1 0",
                     f3, a, b32.load_misaligned, b32.rf_we, b32.in_ready, b32.load_pending);
         end
         tick();
         checks++;
         if (b32.load_misaligned !== 1'b0 || b32.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL misalign_once: mis=%b we=%b, need 0 0", b32.load_misaligned, b32.rf_we);
         end
         return;
      end
      for (int i = 1; i <= lat; i++) begin
         b32.mem_rdata = $urandom;
         checks++;
         if (b32.load_pending !== 1'b1 || b32.in_ready !== 1'b0 || b32.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL stall cyc%0d: pend=%b rdy=%b we=%b, need 1 0 0",
                     i, b32.load_pending, b32.in_ready, b32.rf_we);
         end
         if (i == lat) begin b32.mem_rdata = word; b32.mem_rvalid = 1'b1; end
         tick();
      end
      b32.mem_rvalid = 1'b0;
      exp = ld_model({32'd0, word}, 32, f3, a)[31:0];
      exp_we = rw && rd != 0;
      if (exp_we) exp_ret32++;
      checks++;
      if (b32.rf_we !== exp_we || (exp_we && (b32.rf_wdata !== exp || b32.rf_waddr !== rd))
          || b32.load_pending !== 1'b0 || b32.in_ready !== 1'b1 || b32.retire_count !== 32'(exp_ret32)) begin
         errors++;
         $display("FAIL load32 f3=%0d a=%0d: we=%b d=%h rd=%0d pend=%b rdy=%b ret=%0d, need we=%b d=%h rd=%0d 0 1 ret=%0d",
                  f3, a, b32.rf_we, b32.rf_wdata, b32.rf_waddr, b32.load_pending, b32.in_ready,
                  b32.retire_count, exp_we, exp, rd, exp_ret32);
      end
   endtask

   task automatic op32(input int sel, input logic [4:0] rd, input bit rw);
      logic [31:0] exp;
      bit exp_we;
      b32.in_valid = 1'b1; b32.wb_sel = 2'(sel); b32.rd_addr = rd; b32.reg_write = rw;
      b32.alu_data = $urandom; b32.pc_plus4 = $urandom; b32.imm_data = $urandom;
      b32.mem_rvalid = 1'($urandom_range(0, 1));
      exp = (sel == 0) ? b32.alu_data : (sel == 2) ? b32.pc_plus4 : b32.imm_data;
      exp_we = rw && rd != 0;
      if (exp_we) exp_ret32++;
      tick();
      b32.in_valid = 1'b0; b32.mem_rvalid = 1'b0;
      checks++;
      if (b32.rf_we !== exp_we || (exp_we && (b32.rf_wdata !== exp || b32.rf_waddr !== rd))
          || b32.in_ready !== 1'b1 || b32.retire_count !== 32'(exp_ret32)) begin
         errors++;
         $display("FAIL op32 sel=%0d: we=%b d=%h rd=%0d ret=%0d, need we=%b d=%h rd=%0d ret=%0d",
                  sel, b32.rf_we, b32.rf_wdata, b32.rf_waddr, b32.retire_count, exp_we, exp, rd, exp_ret32);
      end
   endtask

   task automatic load64(input int f3, input int a, input logic [63:0] word, input int lat);
      logic [63:0] exp;
      b64.in_valid = 1'b1; b64.wb_sel = 2'd1; b64.load_funct3 = 3'(f3);
      b64.addr_lo = 3'(a); b64.rd_addr = 5'd9; b64.reg_write = 1'b1;
      tick();
      b64.in_valid = 1'b0;
      if (mis_model(64, f3, a)) begin
         checks++;
         if (b64.load_misaligned !== 1'b1 || b64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL misalign64 f3=%0d a=%0d: mis=%b rdy=%b", f3, a, b64.load_misaligned, b64.in_ready);
         end
         tick();
         return;
      end
      for (int i = 1; i <= lat; i++) begin
         if (i == lat) begin b64.mem_rdata = word; b64.mem_rvalid = 1'b1; end
         tick();
      end
      b64.mem_rvalid = 1'b0;
      exp = ld_model(word, 64, f3, a);
      exp_ret64++;
      checks++;
      if (b64.rf_we !== 1'b1 || b64.rf_wdata !== exp || b64.retire_count !== 32'(exp_ret64)) begin
         errors++;
         $display("FAIL load64 f3=%0d a=%0d: we=%b d=%h ret=%0d, need 1 d=%h ret=%0d",
                  f3, a, b64.rf_we, b64.rf_wdata, b64.retire_count, exp, exp_ret64);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (b32.rf_we !== 1'b0 || b32.rf_waddr !== 5'd0 || b32.rf_wdata !== 32'd0 || b32.load_pending !== 1'b0
          || b32.load_misaligned !== 1'b0 || b32.retire_count !== 32'd0 || b64.rf_wdata !== 64'd0) begin
         errors++;
         $display("FAIL reset_vals: we=%b wa=%0d wd=%h pend=%b mis=%b ret=%0d",
                  b32.rf_we, b32.rf_waddr, b32.rf_wdata, b32.load_pending, b32.load_misaligned, b32.retire_count);
      end
      rst = 1'b0;
      exp_ret32 = 0; exp_ret64 = 0;
      tick();
      checks++;
      if (b32.in_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_reset: got %b need 1", b32.in_ready);
      end
   endtask

   task automatic test_alu();
      b32.in_valid = 1'b1; b32.wb_sel = 2'd0; b32.alu_data = 32'h1234_5678;
      b32.rd_addr = 5'd5; b32.reg_write = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      exp_ret32++;
      checks++;
      if (b32.rf_we !== 1'b1 || b32.rf_waddr !== 5'd5 || b32.rf_wdata !== 32'h1234_5678 || b32.retire_count !== 32'd1) begin
         errors++;
         $display("FAIL alu_first: we=%b wa=%0d wd=%h ret=%0d, need 1 5 12345678 1",
                  b32.rf_we, b32.rf_waddr, b32.rf_wdata, b32.retire_count);
      end
      tick();
      checks++;
      if (b32.rf_we !== 1'b0 || b32.rf_wdata !== 32'h1234_5678 || b32.rf_waddr !== 5'd5) begin
         errors++;
         $display("FAIL hold: we=%b wa=%0d wd=%h, need 0 5 12345678", b32.rf_we, b32.rf_waddr, b32.rf_wdata);
      end
   endtask

   task automatic test_back_to_back();
      b32.in_valid = 1'b1; b32.wb_sel = 2'd0; b32.alu_data = 32'hAAAA_0000;
      b32.rd_addr = 5'd0; b32.reg_write = 1'b1;
      tick();
      checks++;
      if (b32.rf_we !== 1'b0 || b32.in_ready !== 1'b1) begin
         errors++; $display("FAIL x0_suppress: we=%b rdy=%b, need 0 1", b32.rf_we, b32.in_ready);
      end
      b32.wb_sel = 2'd2; b32.pc_plus4 = 32'h104; b32.rd_addr = 5'd3;
      tick();
      b32.in_valid = 1'b0;
      exp_ret32++;
      checks++;
      if (b32.rf_we !== 1'b1 || b32.rf_wdata !== 32'h104 || b32.rf_waddr !== 5'd3 || b32.retire_count !== 32'(exp_ret32)) begin
         errors++;
         $display("FAIL b2b_pc4: we=%b wd=%h wa=%0d ret=%0d, need 1 104 3 %0d",
                  b32.rf_we, b32.rf_wdata, b32.rf_waddr, b32.retire_count, exp_ret32);
      end
   endtask

   task automatic test_load_sign();
      load32(0, 3, 32'h80FF_0000, 4, 5'd7, 1'b1);
      load32(4, 3, 32'h80FF_0000, 4, 5'd7, 1'b1);
      load32(1, 2, 32'h8001_7FFF, 1, 5'd8, 1'b1);
      load32(2, 0, 32'hCAFE_F00D, 2, 5'd9, 1'b1);
   endtask

   task automatic test_misaligned();
      load32(1, 1, 32'h0, 1, 5'd4, 1'b1);
      load32(3, 0, 32'h0, 1, 5'd4, 1'b1);
      load32(7, 0, 32'h0, 1, 5'd4, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = $urandom_range(0, 3);
         if (sel == 1)
            load32($urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom_range(1, 5),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         else
            op32(sel, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_wait_mem();
      b32.in_valid = 1'b1; b32.wb_sel = 2'd1; b32.load_funct3 = 3'd2; b32.addr_lo = 2'd0;
      b32.rd_addr = 5'd6; b32.reg_write = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      b32.mem_rvalid = 1'b1; b32.mem_rdata = 32'h5555_AAAA; rst = 1'b1;
      tick();
      rst = 1'b0; b32.mem_rvalid = 1'b0;
      exp_ret32 = 0; exp_ret64 = 0;
      checks++;
      if (b32.rf_we !== 1'b0 || b32.load_pending !== 1'b0 || b32.in_ready !== 1'b1 || b32.rf_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_wait: we=%b pend=%b rdy=%b wd=%h, need 0 0 1 0",
                  b32.rf_we, b32.load_pending, b32.in_ready, b32.rf_wdata);
      end
      tick();
      checks++;
      if (b32.rf_we !== 1'b0 || b32.retire_count !== 32'd0) begin
         errors++; $display("FAIL reset_no_write: we=%b ret=%0d, need 0 0", b32.rf_we, b32.retire_count);
      end
   endtask

   task automatic test_w64();
      load64(6, 4, 64'hDEADBEEF_0000_0000, 2);
      load64(2, 4, 64'hDEADBEEF_0000_0000, 1);
      load64(3, 0, 64'h8123_4567_89AB_CDEF, 3);
      for (int n = 0; n < 15; n++)
         load64($urandom_range(0, 7), $urandom_range(0, 7), {$urandom, $urandom}, $urandom_range(1, 4));
   endtask

   initial begin
      b32.in_valid = 1'b0; b32.reg_write = 1'b0; b32.rd_addr = '0; b32.wb_sel = '0;
      b32.load_funct3 = '0; b32.addr_lo = '0; b32.alu_data = '0; b32.pc_plus4 = '0;
      b32.imm_data = '0; b32.mem_rdata = '0; b32.mem_rvalid = 1'b0;
      b64.in_valid = 1'b0; b64.reg_write = 1'b0; b64.rd_addr = '0; b64.wb_sel = '0;
      b64.load_funct3 = '0; b64.addr_lo = '0; b64.alu_data = '0; b64.pc_plus4 = '0;
      b64.imm_data = '0; b64.mem_rdata = '0; b64.mem_rvalid = 1'b0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_load_sign();
      test_misaligned();
      test_random();
      test_reset_wait_mem();
      test_w64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
